// File: rtl/popcount_pkg.sv
// Shared types and constants for the popcount accumulator.
package popcount_pkg;

  // Width of the per-beat popcount (0..15 fits in 4 bits).
  localparam int unsigned CNT_W  = 4;
  // Width of the beat counter and the out_beats port.
  localparam int unsigned BEAT_W = 8;

  // Frame FSM: collecting beats, then presenting the result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // One full adder; returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/compressor_15x4.sv
// 15:4 counter built from a full-adder tree; out_3..out_0 is the number of ones on i0..i14.
module compressor_15x4
  import popcount_pkg::*;
(
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic i4,
  input  logic i5,
  input  logic i6,
  input  logic i7,
  input  logic i8,
  input  logic i9,
  input  logic i10,
  input  logic i11,
  input  logic i12,
  input  logic i13,
  input  logic i14,
  output logic out_0,
  output logic out_1,
  output logic out_2,
  output logic out_3
);

  logic [14:0] w_bits;
  logic [4:0]  w_s1;
  logic [4:0]  w_c1;
  logic        w_s2a;
  logic        w_c2a;
  logic        w_c2b;
  logic        w_s3a;
  logic        w_c3a;
  logic        w_s3b;
  logic        w_c3b;
  logic        w_c3c;

  assign w_bits = {i14, i13, i12, i11, i10, i9, i8, i7, i6, i5, i4, i3, i2, i1, i0};

  // First rank: five full adders over the weight-1 inputs.
  for (genvar k = 0; k < 5; k++) begin : g_rank1
    assign {w_c1[k], w_s1[k]} = full_add(w_bits[3*k], w_bits[3*k+1], w_bits[3*k+2]);
  end

  // Weight 1: five partial sums reduce to the result LSB plus two weight-2 carries.
  assign {w_c2a, w_s2a} = full_add(w_s1[0], w_s1[1], w_s1[2]);
  assign {w_c2b, out_0} = full_add(w_s1[3], w_s1[4], w_s2a);

  // Weight 2: seven bits reduce to out_1 plus three weight-4 carries.
  assign {w_c3a, w_s3a} = full_add(w_c1[0], w_c1[1], w_c1[2]);
  assign {w_c3b, w_s3b} = full_add(w_c1[3], w_c1[4], w_c2a);
  assign {w_c3c, out_1} = full_add(w_s3a, w_s3b, w_c2b);

  // Weight 4: three bits give out_2 and the weight-8 MSB.
  assign {out_3, out_2} = full_add(w_c3a, w_c3b, w_c3c);

endmodule

// File: rtl/popcount_accumulator.sv
// Frame popcount accumulator: sums per-beat popcounts over a frame and
// presents a saturating total plus beat count with a valid/ready handshake.
module popcount_accumulator
  import popcount_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned ACC_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [14:0]       in_bits,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [BEAT_W-1:0] out_beats,
  output logic              out_ovf
);

  localparam logic [BEAT_W-1:0] FRAME_LEN_B = BEAT_W'(FRAME_LEN);
  localparam bit                SINGLE_BEAT = (FRAME_LEN == 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    w_acc_nxt;
  logic [BEAT_W-1:0]   r_beats;
  logic [BEAT_W-1:0]   w_beats_nxt;
  logic                r_ovf;
  logic                w_ovf_nxt;
  logic                r_alive;

  logic [CNT_W-1:0]    w_count;
  logic [ACC_W-1:0]    w_count_ext;
  logic [ACC_W:0]      w_sum_wide;
  logic [ACC_W-1:0]    w_sat_acc;
  logic                w_sat_hit;
  logic [BEAT_W-1:0]   w_beats_inc;
  logic                w_len_hit;
  logic                w_accept;

  compressor_15x4 u_compressor (
    .i0    (in_bits[0]),
    .i1    (in_bits[1]),
    .i2    (in_bits[2]),
    .i3    (in_bits[3]),
    .i4    (in_bits[4]),
    .i5    (in_bits[5]),
    .i6    (in_bits[6]),
    .i7    (in_bits[7]),
    .i8    (in_bits[8]),
    .i9    (in_bits[9]),
    .i10   (in_bits[10]),
    .i11   (in_bits[11]),
    .i12   (in_bits[12]),
    .i13   (in_bits[13]),
    .i14   (in_bits[14]),
    .out_0 (w_count[0]),
    .out_1 (w_count[1]),
    .out_2 (w_count[2]),
    .out_3 (w_count[3])
  );

  // in_ready stays low while in reset and rises on the first edge afterwards.
  assign in_ready  = r_alive && (r_state != HOLD);
  assign w_accept  = in_valid && in_ready;

  assign out_valid = (r_state == HOLD);
  assign out_sum   = r_acc;
  assign out_beats = r_beats;
  assign out_ovf   = r_ovf;

  // Saturating add of this beat's count; the extra MSB flags overflow.
  assign w_count_ext = ACC_W'(w_count);
  assign w_sum_wide  = {1'b0, r_acc} + {1'b0, w_count_ext};
  assign w_sat_hit   = w_sum_wide[ACC_W];
  assign w_sat_acc   = w_sat_hit ? {ACC_W{1'b1}} : w_sum_wide[ACC_W-1:0];

  assign w_beats_inc = r_beats + BEAT_W'(1);
  assign w_len_hit   = (w_beats_inc == FRAME_LEN_B);

  // Marks that reset has been released for at least one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alive <= 1'b0;
    end else begin
      r_alive <= 1'b1;
    end
  end

  // State, accumulator, beat counter and overflow flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_beats <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_beats <= w_beats_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Next-state and datapath update for the frame FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_beats_nxt = r_beats;
    w_ovf_nxt   = r_ovf;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_acc_nxt   = w_count_ext;
          w_beats_nxt = BEAT_W'(1);
          w_ovf_nxt   = 1'b0;
          w_state_nxt = (in_last || SINGLE_BEAT) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (w_accept) begin
          w_acc_nxt   = w_sat_acc;
          w_beats_nxt = w_beats_inc;
          w_ovf_nxt   = r_ovf | w_sat_hit;
          // A last beat that also fills the frame still closes it only once.
          if (in_last || w_len_hit) begin
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
          w_acc_nxt   = '0;
          w_beats_nxt = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_popcount_accumulator.sv
// Directed bench: three instances cover FRAME_LEN=4/ACC_W=8, ACC_W=5 saturation and FRAME_LEN=2.
module tb_popcount_accumulator;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // Instance A: FRAME_LEN=4, ACC_W=8
  logic        va, ra, la, ova, orda, ovfa;
  logic [14:0] ba;
  logic [7:0]  suma, beatsa;
  // Instance B: FRAME_LEN=4, ACC_W=5
  logic        vb, rb, lb, ovb, ordb, ovfb;
  logic [14:0] bb;
  logic [4:0]  sumb;
  logic [7:0]  beatsb;
  // Instance C: FRAME_LEN=2, ACC_W=8
  logic        vc, rc, lc, ovc, ordc, ovfc;
  logic [14:0] bc;
  logic [7:0]  sumc, beatsc;

  int n_cmp = 0;
  int n_err = 0;

  popcount_accumulator #(.FRAME_LEN(4), .ACC_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(ra), .in_bits(ba), .in_last(la),
    .out_valid(ova), .out_ready(orda), .out_sum(suma), .out_beats(beatsa), .out_ovf(ovfa)
  );

  popcount_accumulator #(.FRAME_LEN(4), .ACC_W(5)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_ready(rb), .in_bits(bb), .in_last(lb),
    .out_valid(ovb), .out_ready(ordb), .out_sum(sumb), .out_beats(beatsb), .out_ovf(ovfb)
  );

  popcount_accumulator #(.FRAME_LEN(2), .ACC_W(8)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(vc), .in_ready(rc), .in_bits(bc), .in_last(lc),
    .out_valid(ovc), .out_ready(ordc), .out_sum(sumc), .out_beats(beatsc), .out_ovf(ovfc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one beat to the selected instance for a single edge.
  task automatic beat(input int sel, input logic [14:0] bits, input logic last);
    case (sel)
      0: begin va = 1'b1; ba = bits; la = last; end
      1: begin vb = 1'b1; bb = bits; lb = last; end
      default: begin vc = 1'b1; bc = bits; lc = last; end
    endcase
    tick();
    va = 1'b0; vb = 1'b0; vc = 1'b0;
    la = 1'b0; lb = 1'b0; lc = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    va = 1'b0; vb = 1'b0; vc = 1'b0;
    la = 1'b0; lb = 1'b0; lc = 1'b0;
    ba = '0;   bb = '0;   bc = '0;
    orda = 1'b1; ordb = 1'b1; ordc = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_in_ready", 32'(ra), 0);
    chk("rst_out_valid", 32'(ova), 0);
    chk("rst_out_sum", 32'(suma), 0);
    chk("rst_out_beats", 32'(beatsa), 0);
    chk("rst_out_ovf", 32'(ovfa), 0);
    rst_n = 1'b1;
    #1;
    chk("rdy_before_edge", 32'(ra), 0);
    tick();
    chk("rdy_after_edge", 32'(ra), 1);

    // Four full beats: 4 x 15 = 60
    beat(0, 15'h7FFF, 1'b0);
    beat(0, 15'h7FFF, 1'b0);
    beat(0, 15'h7FFF, 1'b0);
    chk("full_valid_early", 32'(ova), 0);
    beat(0, 15'h7FFF, 1'b0);
    chk("full_valid", 32'(ova), 1);
    chk("full_sum", 32'(suma), 60);
    chk("full_beats", 32'(beatsa), 4);
    chk("full_ovf", 32'(ovfa), 0);
    chk("full_hold_rdy", 32'(ra), 0);
    tick();
    chk("full_done_valid", 32'(ova), 0);
    chk("full_done_rdy", 32'(ra), 1);

    // Early last (1 + 2 = 3) followed by backpressure
    orda = 1'b0;
    beat(0, 15'h0001, 1'b0);
    beat(0, 15'h0003, 1'b1);
    chk("early_valid", 32'(ova), 1);
    chk("early_sum", 32'(suma), 3);
    chk("early_beats", 32'(beatsa), 2);
    va = 1'b1;
    ba = 15'h7FFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(ova), 1);
      chk("bp_sum", 32'(suma), 3);
      chk("bp_beats", 32'(beatsa), 2);
      chk("bp_rdy", 32'(ra), 0);
    end
    va = 1'b0;
    orda = 1'b1;
    tick();
    chk("bp_done_valid", 32'(ova), 0);
    chk("bp_done_rdy", 32'(ra), 1);

    // Zero beats still count; idle cycles in ACCUM are a plain stall
    beat(0, 15'h0000, 1'b0);
    repeat (3) tick();
    chk("stall_valid", 32'(ova), 0);
    chk("stall_rdy", 32'(ra), 1);
    beat(0, 15'h5555, 1'b0);
    beat(0, 15'h0000, 1'b1);
    chk("zero_valid", 32'(ova), 1);
    chk("zero_sum", 32'(suma), 8);
    chk("zero_beats", 32'(beatsa), 3);
    tick();

    // Saturation with ACC_W=5: 45 clips to 31
    beat(1, 15'h7FFF, 1'b0);
    beat(1, 15'h7FFF, 1'b0);
    beat(1, 15'h7FFF, 1'b1);
    chk("sat_valid", 32'(ovb), 1);
    chk("sat_sum", 32'(sumb), 31);
    chk("sat_beats", 32'(beatsb), 3);
    chk("sat_ovf", 32'(ovfb), 1);
    tick();
    chk("sat_ovf_cleared", 32'(ovfb), 0);
    beat(1, 15'h0007, 1'b1);
    chk("post_sat_sum", 32'(sumb), 3);
    chk("post_sat_ovf", 32'(ovfb), 0);
    chk("post_sat_beats", 32'(beatsb), 1);
    tick();
    // Exactly 31 is not an overflow
    beat(1, 15'h7FFF, 1'b0);
    beat(1, 15'h7FFF, 1'b0);
    beat(1, 15'h0001, 1'b1);
    chk("max_sum", 32'(sumb), 31);
    chk("max_ovf", 32'(ovfb), 0);
    tick();

    // FRAME_LEN=2: last coincides with the length limit
    beat(2, 15'h0011, 1'b0);
    chk("simul_valid_early", 32'(ovc), 0);
    beat(2, 15'h0111, 1'b1);
    chk("simul_valid", 32'(ovc), 1);
    chk("simul_sum", 32'(sumc), 5);
    chk("simul_beats", 32'(beatsc), 2);
    tick();
    chk("simul_done", 32'(ovc), 0);
    repeat (3) tick();
    chk("simul_no_extra", 32'(ovc), 0);
    beat(2, 15'h7FFF, 1'b0);
    beat(2, 15'h0000, 1'b0);
    chk("len_valid", 32'(ovc), 1);
    chk("len_sum", 32'(sumc), 15);
    chk("len_beats", 32'(beatsc), 2);
    tick();

    // Reset mid-frame discards the partial frame
    beat(0, 15'h7FFF, 1'b0);
    beat(0, 15'h7FFF, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy", 32'(ra), 0);
    chk("mid_rst_valid", 32'(ova), 0);
    chk("mid_rst_sum", 32'(suma), 0);
    chk("mid_rst_beats", 32'(beatsa), 0);
    chk("mid_rst_ovf", 32'(ovfa), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_rdy_back", 32'(ra), 1);
    chk("mid_rst_no_valid", 32'(ova), 0);
    beat(0, 15'h00FF, 1'b1);
    chk("fresh_valid", 32'(ova), 1);
    chk("fresh_sum", 32'(suma), 8);
    chk("fresh_beats", 32'(beatsa), 1);
    tick();
    chk("fresh_done", 32'(ova), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
